prbs31_checker: RTL and testbench
=================================

# prbs31_checker

Receive-side PRBS31 checker pairing with the team's PRBS31 generator (polynomial x^31 + x^28 + 1, new bit = s[30] ^ s[27], shifted in at bit 0). It samples a serial bit stream, self-synchronises to the sequence and declares lock. It then counts bit errors against a free-running local replica, and drops lock when the error density in a sliding window is too high. It sits on the input side of the test-pattern path, typically fed from a dedicated input pin.

## Interface
- LOCK_COUNT, 64: consecutive matching bits required in HUNT before LOCKED.
- WINDOW, 256: valid-bit length of the error-density window in LOCKED.
- UNLOCK_ERRS, 8: errors within one window that force loss of lock.
- ERR_W, 16: width of the saturating error counter.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset: rst_n, asynchronous, active-high.
- rx_valid  in  1  qualifies rx_bit; no state changes on cycles where it is low.
- rx_bit  in  1  received serial bit.
- clr_cnt  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per detected error.
- err_count  out  ERR_W  saturating total error count since reset or clr_cnt.

## Operation
- History register h[30:0] shifts left on each valid bit; h[0] is the newest bit. Prediction: p = h[30] ^ h[27].
- FSM states:
  - SEED: load rx_bit into h; seed counter counts to 31, then go to HUNT.
  - HUNT: load rx_bit into h; compare rx_bit to p.
    - Match: increment match counter.
    - Mismatch: clear match counter and stay in HUNT. No err_pulse and no err_count change.
    - Match counter reaching LOCK_COUNT: go to LOCKED.
  - LOCKED: load p (not rx_bit) into h, so the local replica free-runs and a single flipped bit yields exactly one error.
    - Mismatch: err_pulse, err_count++, win_errs++.
- All-zero guard: in HUNT, when h == 0 a "match" does not increment the match counter. A stuck-at-0 input must never lock.
- Window in LOCKED:
  - win_cnt counts valid bits 0..WINDOW-1. On wrap, win_cnt and win_errs clear.
  - When win_errs reaches UNLOCK_ERRS, go to SEED. Seed, match and window counters clear; h is kept but is reloaded by SEED.
- err_count saturates at all-ones; further errors still pulse err_pulse.
- clr_cnt together with an error on the same cycle: err_count = 1.
- err_count persists across loss of lock; only reset or clr_cnt clears it.

## Timing
- All outputs registered. err_pulse and err_count update in the cycle after the rx_valid sample carrying the error.
- locked rises on the cycle after the LOCK_COUNT-th qualifying match.
- locked falls on the cycle after the sample that brings win_errs to UNLOCK_ERRS; that error is itself counted.
- Minimum lock latency from reset with a clean stream: 31 + LOCK_COUNT valid bits.
- Reset values: state SEED, h = 0, all internal counters 0, locked 0, err_pulse 0, err_count 0.
- Reset mid-operation: immediate return to the reset values, independent of clk.
- rx_valid gaps: state, h and all counters hold; err_pulse is 0 on non-valid cycles.

## Structure
- Package prbs31_pkg holds:
  - PRBS_LEN = 31, TAP_A = 30, TAP_B = 27;
  - the state enum {SEED, HUNT, LOCKED};
  - a next-bit function shared with the generator.
- One sub-module, prbs31_sat_counter (ERR_W-bit saturating counter with clear-plus-increment semantics), instantiated for err_count.

## Test plan
- Generator stream from seed 1, rx_valid always high -> locked rises after exactly 95 valid bits; err_count stays 0 for 10,000 bits.
- Locked; flip one bit -> exactly one err_pulse, err_count = 1, locked stays high.
- Constant 0 input for 1,000 bits -> locked never asserts, err_count = 0.
- Locked; 8 bit flips within 200 bits -> locked falls after the 8th; err_count = 8. Clean stream then re-locks after 95 bits.
- ERR_W = 4, locked with error density below threshold -> err_count sticks at 15 while err_pulse keeps firing. clr_cnt coincident with an error -> err_count = 1.
- rx_valid toggling 50% with a clean stream -> lock after 95 valid samples. Assert rst_n mid-LOCKED -> locked = 0 and err_count = 0 immediately.

Source files
------------

// File: rtl/prbs31_pkg.sv
// prbs31_pkg
// Shared definitions for the PRBS31 test-pattern path (x^31 + x^28 + 1).
// Holds the register length and tap positions, the checker state encoding
// and the next-bit function used by both the generator and the checker,
// so that the two sides cannot drift apart.
package prbs31_pkg;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;

  // SEED: fill the history from the line; HUNT: look for a run of matches;
  // LOCKED: free-running local replica, count errors.
  typedef enum logic [1:0] {
    SEED,
    HUNT,
    LOCKED
  } prbs31_state_e;

  // The bit that follows the current 31-bit window; it is shifted in at bit 0.
  function automatic logic prbs31_next_bit(input logic [PRBS_LEN-1:0] state);
    return state[TAP_A] ^ state[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_sat_counter.sv
// prbs31_sat_counter
// Saturating up-counter with synchronous clear. A clear on the same cycle
// as an increment leaves the counter at 1, so the event that coincides with
// the clear is not lost.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous reset, active-high
//   clr    in   synchronous clear
//   inc    in   count one event
//   count  out  WIDTH-bit count, sticks at all-ones
module prbs31_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? WIDTH'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prbs31_checker.sv
// prbs31_checker
// Receive-side PRBS31 checker. Seeds a 31-bit history from the incoming
// serial stream, hunts for LOCK_COUNT consecutive correct predictions, then
// switches to a free-running local replica and counts bit errors. Lock is
// dropped when UNLOCK_ERRS errors land inside one WINDOW-bit window.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active-high
//   rx_valid   in   qualifies rx_bit; nothing changes while low
//   rx_bit     in   received serial bit
//   clr_cnt    in   synchronous clear of err_count
//   locked     out  high while in LOCKED (registered)
//   err_pulse  out  one-cycle pulse per detected error (registered)
//   err_count  out  saturating error count since reset or clr_cnt
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOCK_COUNT  = 64,
  parameter int WINDOW      = 256,
  parameter int UNLOCK_ERRS = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic             rx_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int SEED_W  = $clog2(PRBS_LEN + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(PRBS_LEN - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_MAX   = WERR_W'(UNLOCK_ERRS);

  prbs31_state_e       state_q, state_d;
  logic [PRBS_LEN-1:0] h_q, h_d;
  logic [SEED_W-1:0]   seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]   win_errs_q, win_errs_d;
  logic [WERR_W-1:0]   win_errs_inc;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic                pred;
  logic                err_hit;

  assign pred = prbs31_next_bit(h_q);

  // Next-state logic. In LOCKED the history is fed with its own prediction
  // rather than rx_bit, so a single corrupted bit on the line is counted once
  // instead of propagating through the taps as three errors.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    seed_cnt_d   = seed_cnt_q;
    match_cnt_d  = match_cnt_q;
    win_cnt_d    = win_cnt_q;
    win_errs_d   = win_errs_q;
    win_errs_inc = win_errs_q;
    err_hit      = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        SEED: begin
          h_d = {h_q[PRBS_LEN-2:0], rx_bit};
          if (seed_cnt_q == SEED_LAST) begin
            seed_cnt_d = '0;
            state_d    = HUNT;
          end else begin
            seed_cnt_d = seed_cnt_q + SEED_W'(1);
          end
        end

        HUNT: begin
          h_d = {h_q[PRBS_LEN-2:0], rx_bit};
          if (rx_bit == pred) begin
            // An all-zero history predicts zero forever; a stuck-low line
            // must not be mistaken for a valid sequence.
            if (h_q != '0) begin
              if (match_cnt_q == MATCH_LAST) begin
                match_cnt_d = '0;
                win_cnt_d   = '0;
                win_errs_d  = '0;
                state_d     = LOCKED;
              end else begin
                match_cnt_d = match_cnt_q + MATCH_W'(1);
              end
            end
          end else begin
            match_cnt_d = '0;
          end
        end

        LOCKED: begin
          h_d          = {h_q[PRBS_LEN-2:0], pred};
          err_hit      = (rx_bit != pred);
          win_errs_inc = win_errs_q + WERR_W'(err_hit);
          // An error on the last bit of a window still belongs to that
          // window, so the unlock test comes before the window wrap.
          if (win_errs_inc == WERR_MAX) begin
            seed_cnt_d  = '0;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_errs_d  = '0;
            state_d     = SEED;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d  = '0;
            win_errs_d = '0;
          end else begin
            win_cnt_d  = win_cnt_q + WIN_W'(1);
            win_errs_d = win_errs_inc;
          end
        end

        default: begin
          state_d = SEED;
        end
      endcase
    end

    locked_d    = (state_d == LOCKED);
    err_pulse_d = err_hit;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= SEED;
      h_q         <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_errs_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_errs_q  <= win_errs_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  prbs31_sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (err_hit),
    .count (err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// tb_prbs31_checker
// Drives a PRBS31 stream (with injected bit flips, idle gaps, stuck-low
// input and resets) into two checkers, one with a 16-bit and one with a
// 4-bit error counter, and compares every cycle against a queue-based
// model of the checking rules.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic        rx_bit;
  logic        clr_cnt;
  logic        locked16, err_pulse16, locked4, err_pulse4;
  logic [15:0] err_count16;
  logic [3:0]  err_count4;

  int compare_count = 0;
  int fail_count    = 0;

  logic [30:0] gen_state;

  // Reference model: mode 0 = seed, 1 = hunt, 2 = locked.
  int m_mode;
  bit m_hist[$];
  int m_seed_n, m_match_n, m_win_n, m_win_errs, m_total;
  bit exp_locked, exp_pulse;
  int exp_count16, exp_count4;

  prbs31_checker dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_bit    (rx_bit),
    .clr_cnt   (clr_cnt),
    .locked    (locked16),
    .err_pulse (err_pulse16),
    .err_count (err_count16)
  );

  prbs31_checker #(
    .ERR_W (4)
  ) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_bit    (rx_bit),
    .clr_cnt   (clr_cnt),
    .locked    (locked4),
    .err_pulse (err_pulse4),
    .err_count (err_count4)
  );

  always #5 clk = ~clk;

  // Global time limit so a stuck run still ends with a report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_mode = 0;
    m_hist.delete();
    repeat (31) m_hist.push_back(1'b0);
    m_seed_n    = 0;
    m_match_n   = 0;
    m_win_n     = 0;
    m_win_errs  = 0;
    m_total     = 0;
    exp_locked  = 1'b0;
    exp_pulse   = 1'b0;
    exp_count16 = 0;
    exp_count4  = 0;
  endtask

  // m_hist[0] is the oldest of the last 31 bits, so the taps x^31 and x^28
  // are entries 0 and 3.
  task automatic modelStep(input bit valid, input bit b, input bit clr);
    bit err;
    bit p;
    bit all_zero;
    err = 1'b0;
    if (valid) begin
      p = m_hist[0] ^ m_hist[3];
      all_zero = 1'b1;
      foreach (m_hist[i]) if (m_hist[i]) all_zero = 1'b0;
      case (m_mode)
        0: begin
          m_hist.push_back(b);
          m_seed_n++;
          if (m_seed_n == 31) begin
            m_mode   = 1;
            m_seed_n = 0;
          end
        end
        1: begin
          m_hist.push_back(b);
          if (b == p) begin
            if (!all_zero) begin
              m_match_n++;
              if (m_match_n == 64) begin
                m_mode     = 2;
                m_match_n  = 0;
                m_win_n    = 0;
                m_win_errs = 0;
              end
            end
          end else begin
            m_match_n = 0;
          end
        end
        default: begin
          m_hist.push_back(p);
          err = (b != p);
          if (err) m_win_errs++;
          m_win_n++;
          if (m_win_errs == 8) begin
            m_mode     = 0;
            m_seed_n   = 0;
            m_match_n  = 0;
            m_win_n    = 0;
            m_win_errs = 0;
          end else if (m_win_n == 256) begin
            m_win_n    = 0;
            m_win_errs = 0;
          end
        end
      endcase
      void'(m_hist.pop_front());
    end
    m_total     = clr ? int'(err) : m_total + int'(err);
    exp_pulse   = err;
    exp_locked  = (m_mode == 2);
    exp_count16 = (m_total > 65535) ? 65535 : m_total;
    exp_count4  = (m_total > 15) ? 15 : m_total;
  endtask

  task automatic applyStimulus(input bit valid, input bit b, input bit clr);
    rx_valid = valid;
    rx_bit   = b;
    clr_cnt  = clr;
    modelStep(valid, b, clr);
    @(posedge clk);
    #1;
    checkOutput("locked", locked16, exp_locked);
    checkOutput("err_pulse", err_pulse16, exp_pulse);
    checkOutput("err_count", err_count16, exp_count16);
    checkOutput("locked_w4", locked4, exp_locked);
    checkOutput("err_count_w4", err_count4, exp_count4);
  endtask

  task automatic genBit(output bit b);
    b = gen_state[30] ^ gen_state[27];
    gen_state = {gen_state[29:0], b};
  endtask

  task automatic sendBit(input bit flip, input bit clr);
    bit g;
    genBit(g);
    applyStimulus(1'b1, g ^ flip, clr);
  endtask

  task automatic doReset();
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
    clr_cnt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    modelReset();
  endtask

  // Sends clean bits (optionally with random idle gaps) and reports the
  // number of valid bits after which locked was first seen high.
  task automatic runUntilLock(input bit gaps, output int lock_at);
    int n;
    n = 0;
    lock_at = -1;
    while (n < 400 && lock_at < 0) begin
      if (gaps) repeat ($urandom_range(2, 0)) applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      sendBit(1'b0, 1'b0);
      n++;
      if (locked16 === 1'b1) lock_at = n;
    end
  endtask

  initial begin
    int lock_at;
    int pulses;
    int guard;
    bit ever;

    rst_n     = 1'b1;
    rx_valid  = 1'b0;
    rx_bit    = 1'b0;
    clr_cnt   = 1'b0;
    gen_state = 31'd1;
    doReset();

    checkOutput("reset_locked", locked16, 0);
    checkOutput("reset_err_pulse", err_pulse16, 0);
    checkOutput("reset_err_count", err_count16, 0);
    checkOutput("reset_err_count_w4", err_count4, 0);

    // Clean stream from seed 1: lock after exactly 31 + 64 valid bits.
    runUntilLock(1'b0, lock_at);
    checkOutput("lock_latency", lock_at, 95);
    repeat (10000 - 95) sendBit(1'b0, 1'b0);
    checkOutput("clean_err_count", err_count16, 0);

    // One flipped bit gives exactly one error.
    pulses = 0;
    sendBit(1'b1, 1'b0);
    pulses += int'(err_pulse16);
    repeat (50) begin
      sendBit(1'b0, 1'b0);
      pulses += int'(err_pulse16);
    end
    checkOutput("single_flip_pulses", pulses, 1);
    checkOutput("single_flip_count", err_count16, 1);
    checkOutput("single_flip_locked", locked16, 1);

    // Eight flips inside one window, starting on a window boundary.
    sendBit(1'b0, 1'b1);
    checkOutput("clr_count", err_count16, 0);
    guard = 0;
    while (m_win_n != 0 && guard < 300) begin
      sendBit(1'b0, 1'b0);
      guard++;
    end
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(24, 0)) sendBit(1'b0, 1'b0);
      if (k == 7) checkOutput("locked_before_8th", locked16, 1);
      sendBit(1'b1, 1'b0);
    end
    checkOutput("unlock_after_8th", locked16, 0);
    checkOutput("burst_err_count", err_count16, 8);
    runUntilLock(1'b0, lock_at);
    checkOutput("relock_latency", lock_at, 95);

    // Sparse errors (never 8 per window): 4-bit count saturates, pulses go on.
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      repeat (39) sendBit(1'b0, 1'b0);
      sendBit(1'b1, 1'b0);
      pulses += int'(err_pulse4);
    end
    checkOutput("sat_count_w4", err_count4, 15);
    checkOutput("sat_pulses_w4", pulses, 20);
    checkOutput("sat_count_w16", err_count16, 28);
    checkOutput("sat_locked", locked16, 1);
    repeat (39) sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b1);
    checkOutput("clr_with_err", err_count16, 1);
    checkOutput("clr_with_err_w4", err_count4, 1);

    // Asynchronous reset while locked with a nonzero count.
    repeat (39) sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    #3;
    rst_n = 1'b1;
    #1;
    checkOutput("async_rst_locked", locked16, 0);
    checkOutput("async_rst_count", err_count16, 0);
    checkOutput("async_rst_count_w4", err_count4, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    modelReset();

    // Stuck-low line must never lock.
    ever = 1'b0;
    repeat (1000) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (locked16 !== 1'b0) ever = 1'b1;
    end
    checkOutput("stuck0_never_locked", ever, 0);
    checkOutput("stuck0_count", err_count16, 0);

    // Gapped clean stream: latency counted in valid samples only.
    doReset();
    gen_state = 31'd1;
    runUntilLock(1'b1, lock_at);
    checkOutput("gapped_lock_latency", lock_at, 95);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
